// File: rtl/intest_bist_controller.sv
// BIST driver/checker for the serial-adder CUT: LFSR pattern source, start/done
// handshake with per-pattern timeout, MISR response compaction and golden compare.
module intest_bist_controller #(
  parameter int unsigned     NUM_PATTERNS = 256,
  parameter int unsigned     TIMEOUT      = 64,
  parameter logic [127:0]    LFSR_SEED    = 128'h1,
  parameter logic [65:0]     GOLDEN_SIG   = 66'h0
) (
  input  logic           cirCLK,
  input  logic           cirRST,
  input  logic           bistStart,
  input  logic [65:0]    cutOutput,
  output logic           cutStart,
  output logic [127:0]   cutInput,
  output logic           bistBusy,
  output logic           bistDone,
  output logic           bistPass,
  output logic           bistTimeout,
  output logic [65:0]    signature,
  output logic [15:0]    patternCount
);

  localparam int unsigned W_LFSR = 128;
  localparam int unsigned W_MISR = 66;
  localparam int unsigned W_CNT  = 16;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [W_LFSR-1:0] SEED_EFF = (LFSR_SEED == '0) ? W_LFSR'(1) : LFSR_SEED;
  localparam logic [W_CNT-1:0]  NUM_CNT  = W_CNT'(NUM_PATTERNS);
  localparam logic [W_CNT-1:0]  TMO_CNT  = W_CNT'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_COMPARE = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t              r_state;
  logic [W_LFSR-1:0]   r_lfsr;
  logic [W_MISR-1:0]   r_misr;
  logic [W_CNT-1:0]    r_timer;
  logic [W_CNT-1:0]    r_count;
  logic                r_cut_start;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic                r_timeout;

  state_t              w_state_next;
  logic [W_LFSR-1:0]   w_lfsr_next;
  logic [W_MISR-1:0]   w_misr_next;
  logic [W_CNT-1:0]    w_timer_next;
  logic [W_CNT-1:0]    w_count_next;
  logic                w_pass_next;
  logic                w_timeout_next;
  logic                w_cut_start_next;
  logic                w_busy_next;
  logic                w_done_next;

  logic [W_LFSR-1:0]   w_lfsr_shift;
  logic [W_MISR-1:0]   w_misr_shift;
  logic                w_done_qual;

  assign w_lfsr_shift = {r_lfsr[126:0], r_lfsr[127] ^ r_lfsr[125] ^ r_lfsr[100] ^ r_lfsr[98]};
  assign w_misr_shift = {r_misr[64:0], r_misr[65] ^ r_misr[64] ^ r_misr[55] ^ r_misr[46]};

  // Timer is zero only in the first WAIT cycle, which blanks a stale done.
  assign w_done_qual = cutOutput[0] && (r_timer != '0);

  // Next-state and next-register logic.
  always_comb begin
    w_state_next   = r_state;
    w_lfsr_next    = r_lfsr;
    w_misr_next    = r_misr;
    w_timer_next   = r_timer;
    w_count_next   = r_count;
    w_pass_next    = r_pass;
    w_timeout_next = r_timeout;

    unique case (r_state)
      S_IDLE, S_FINISH: begin
        if (bistStart) begin
          w_state_next   = S_APPLY;
          w_lfsr_next    = SEED_EFF;
          w_misr_next    = '0;
          w_timer_next   = '0;
          w_count_next   = '0;
          w_pass_next    = 1'b0;
          w_timeout_next = 1'b0;
        end
      end

      S_APPLY: begin
        w_timer_next = '0;
        w_state_next = S_WAIT;
      end

      S_WAIT: begin
        w_timer_next = r_timer + W_CNT'(1);
        if (w_done_qual) begin
          w_state_next = S_CAPTURE;
        end else if (r_timer >= TMO_CNT) begin
          w_state_next   = S_FINISH;
          w_timeout_next = 1'b1;
          w_pass_next    = 1'b0;
        end
      end

      S_CAPTURE: begin
        w_misr_next = w_misr_shift ^ cutOutput;
        w_lfsr_next = w_lfsr_shift;
        if (r_count < NUM_CNT) begin
          w_count_next = r_count + W_CNT'(1);
        end
        w_state_next = (w_count_next == NUM_CNT) ? S_COMPARE : S_APPLY;
      end

      S_COMPARE: begin
        w_pass_next  = (r_misr == GOLDEN_SIG);
        w_state_next = S_FINISH;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    w_cut_start_next = (w_state_next == S_APPLY);
    w_busy_next      = (w_state_next == S_APPLY)   || (w_state_next == S_WAIT) ||
                       (w_state_next == S_CAPTURE) || (w_state_next == S_COMPARE);
    w_done_next      = (w_state_next == S_FINISH);
  end

  // State and output registers.
  always_ff @(posedge cirCLK or posedge cirRST) begin
    if (cirRST) begin
      r_state     <= S_IDLE;
      r_lfsr      <= SEED_EFF;
      r_misr      <= '0;
      r_timer     <= '0;
      r_count     <= '0;
      r_cut_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_lfsr      <= w_lfsr_next;
      r_misr      <= w_misr_next;
      r_timer     <= w_timer_next;
      r_count     <= w_count_next;
      r_cut_start <= w_cut_start_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_pass      <= w_pass_next;
      r_timeout   <= w_timeout_next;
    end
  end

  assign cutStart     = r_cut_start;
  assign cutInput     = r_lfsr;
  assign bistBusy     = r_busy;
  assign bistDone     = r_done;
  assign bistPass     = r_pass;
  assign bistTimeout  = r_timeout;
  assign signature    = r_misr;
  assign patternCount = r_count;

endmodule

// File: tb/tb_intest_bist_controller.sv
// Directed bench: fault-free, stuck-at, no-done, always-done and reset/restart scenarios.
module tb_intest_bist_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, start1, start2, start3;
  logic [65:0]  cut_out0, cut_out1, cut_out2, cut_out3;
  logic         cs0, cs1, cs2, cs3;
  logic [127:0] ci0, ci1, ci2, ci3;
  logic         busy0, busy1, busy2, busy3;
  logic         done0, done1, done2, done3;
  logic         pass0, pass1, pass2, pass3;
  logic         to0, to1, to2, to3;
  logic [65:0]  sig0, sig1, sig2, sig3;
  logic [15:0]  cnt0, cnt1, cnt2, cnt3;

  int n_tests = 0;
  int n_fail  = 0;

  // Fault-free run, golden 0xF for inputs 1,2,4,8 with B=0.
  intest_bist_controller #(.NUM_PATTERNS(4), .TIMEOUT(64), .LFSR_SEED(128'h1), .GOLDEN_SIG(66'hF)) u0 (
    .cirCLK(clk), .cirRST(rst), .bistStart(start0), .cutOutput(cut_out0), .cutStart(cs0),
    .cutInput(ci0), .bistBusy(busy0), .bistDone(done0), .bistPass(pass0), .bistTimeout(to0),
    .signature(sig0), .patternCount(cnt0));

  intest_bist_controller #(.NUM_PATTERNS(4), .TIMEOUT(64), .LFSR_SEED(128'h1), .GOLDEN_SIG(66'hF)) u1 (
    .cirCLK(clk), .cirRST(rst), .bistStart(start1), .cutOutput(cut_out1), .cutStart(cs1),
    .cutInput(ci1), .bistBusy(busy1), .bistDone(done1), .bistPass(pass1), .bistTimeout(to1),
    .signature(sig1), .patternCount(cnt1));

  intest_bist_controller #(.NUM_PATTERNS(4), .TIMEOUT(8), .LFSR_SEED(128'h1), .GOLDEN_SIG(66'h0)) u2 (
    .cirCLK(clk), .cirRST(rst), .bistStart(start2), .cutOutput(cut_out2), .cutStart(cs2),
    .cutInput(ci2), .bistBusy(busy2), .bistDone(done2), .bistPass(pass2), .bistTimeout(to2),
    .signature(sig2), .patternCount(cnt2));

  intest_bist_controller #(.NUM_PATTERNS(4), .TIMEOUT(64), .LFSR_SEED(128'h0), .GOLDEN_SIG(66'hF)) u3 (
    .cirCLK(clk), .cirRST(rst), .bistStart(start3), .cutOutput(cut_out3), .cutStart(cs3),
    .cutInput(ci3), .bistBusy(busy3), .bistDone(done3), .bistPass(pass3), .bistTimeout(to3),
    .signature(sig3), .patternCount(cnt3));

  // Adder CUT models: done raised 3 edges after start is sampled, held until next start.
  logic [1:0]   m0_cnt, m1_cnt;
  logic [127:0] m0_op, m1_op;
  logic [64:0]  m0_sum, m1_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_cnt <= 2'd0;
      m0_op  <= '0;
    end else if (cs0) begin
      m0_cnt <= 2'd1;
      m0_op  <= ci0;
    end else if ((m0_cnt == 2'd1) || (m0_cnt == 2'd2)) begin
      m0_cnt <= m0_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m1_cnt <= 2'd0;
      m1_op  <= '0;
    end else if (cs1) begin
      m1_cnt <= 2'd1;
      m1_op  <= ci1;
    end else if ((m1_cnt == 2'd1) || (m1_cnt == 2'd2)) begin
      m1_cnt <= m1_cnt + 2'd1;
    end
  end

  always_comb begin
    m0_sum   = {1'b0, m0_op[63:0]} + {1'b0, m0_op[127:64]};
    m1_sum   = {1'b0, m1_op[63:0]} + {1'b0, m1_op[127:64]};
    cut_out0 = {m0_sum[63:0], m0_sum[64], m0_cnt == 2'd3};
    // Result bit 0 stuck at 1.
    cut_out1 = {m1_sum[63:0], m1_sum[64], m1_cnt == 2'd3} | 66'h4;
    cut_out2 = 66'h0;
    cut_out3 = 66'h1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    tick(2);

    chk("rst_sig", sig0, 0);
    chk("rst_input", ci0, 1);
    chk("rst_start", cs0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_timeout", to0, 0);
    chk("rst_count", cnt0, 0);
    rst = 1'b0;
    tick(1);

    // Fault-free and stuck-at runs in lockstep; S = APPLY entry edge.
    start0 = 1'b1; start1 = 1'b1;
    tick(1);
    start0 = 1'b0; start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("pulse_start0", cs0, 1);
      chk("pattern0", ci0, 128'h1 << k);
      chk("pulse_start1", cs1, 1);
      chk("pattern1", ci1, 128'h1 << k);
      tick(1);
      chk("pulse_end", cs0, 0);
      chk("busy_wait", busy0, 1);
      chk("busy_wait1", busy1, 1);
      tick(4);
    end
    chk("compare_done", done0, 0);
    chk("compare_busy", busy0, 1);
    chk("compare_count", cnt0, 4);
    tick(1);
    chk("good_done", done0, 1);
    chk("good_pass", pass0, 1);
    chk("good_sig", sig0, 66'hF);
    chk("good_count", cnt0, 4);
    chk("good_timeout", to0, 0);
    chk("good_busy", busy0, 0);
    chk("stuck_done", done1, 1);
    chk("stuck_pass", pass1, 0);
    chk("stuck_sig", sig1, 66'h13);
    chk("stuck_timeout", to1, 0);
    chk("stuck_count", cnt1, 4);
    tick(3);
    chk("hold_done", done0, 1);
    chk("hold_sig", sig0, 66'hF);

    // No-done CUT, TIMEOUT=8: FINISH 10 edges after APPLY entry.
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    chk("tmo_start", cs2, 1);
    chk("tmo_input", ci2, 1);
    chk("tmo_busy", busy2, 1);
    tick(9);
    chk("tmo_done_early", done2, 0);
    tick(1);
    chk("tmo_done", done2, 1);
    chk("tmo_flag", to2, 1);
    chk("tmo_pass", pass2, 0);
    chk("tmo_count", cnt2, 0);
    chk("tmo_sig", sig2, 0);
    chk("tmo_busy_end", busy2, 0);
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    chk("tmo_flag_clear", to2, 0);
    chk("tmo_done_clear", done2, 0);

    // Permanent done, zero seed: capture only in the 2nd WAIT cycle.
    start3 = 1'b1;
    tick(1);
    start3 = 1'b0;
    chk("seed0_input", ci3, 1);
    chk("blank_start", cs3, 1);
    tick(2);
    chk("blank_wait2_count", cnt3, 0);
    chk("blank_wait2_start", cs3, 0);
    tick(1);
    chk("blank_capture_count", cnt3, 0);
    chk("blank_capture_busy", busy3, 1);
    tick(1);
    chk("blank_apply2_count", cnt3, 1);
    chk("blank_apply2_start", cs3, 1);
    chk("blank_apply2_input", ci3, 2);
    tick(13);
    chk("blank_done", done3, 1);
    chk("blank_sig", sig3, 66'hF);
    chk("blank_pass", pass3, 1);
    chk("blank_timeout", to3, 0);
    chk("blank_count", cnt3, 4);

    // Async reset in WAIT of pattern 2.
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    tick(7);
    chk("mid_count", cnt0, 1);
    chk("mid_busy", busy0, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy0, 0);
    chk("arst_count", cnt0, 0);
    chk("arst_sig", sig0, 0);
    chk("arst_input", ci0, 1);
    chk("arst_start", cs0, 0);
    chk("arst_done", done0, 0);
    chk("arst_pass", pass0, 0);
    chk("arst_timeout", to0, 0);
    #2 rst = 1'b0;
    tick(1);

    // Rerun after reset; start raised mid-run and held through FINISH.
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    tick(10);
    start0 = 1'b1;
    tick(11);
    chk("rerun_done", done0, 1);
    chk("rerun_sig", sig0, 66'hF);
    chk("rerun_pass", pass0, 1);
    chk("rerun_count", cnt0, 4);
    tick(1);
    chk("b2b_start", cs0, 1);
    chk("b2b_done", done0, 0);
    chk("b2b_busy", busy0, 1);
    chk("b2b_sig", sig0, 0);
    chk("b2b_count", cnt0, 0);
    chk("b2b_input", ci0, 1);
    tick(21);
    chk("b2b_done2", done0, 1);
    chk("b2b_sig2", sig0, 66'hF);
    chk("b2b_pass2", pass0, 1);
    start0 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
